// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue and exec-unit sequencer.
// Latency: a ready op pushed in cycle N is evaluated in N+1. exec_enable is high in N+2..N+4 and done_valid is high in N+4.
// Backpressure: disp_ready=0 while full. Issue is strictly in order, and a non-eligible head stalls the queue.
//
// Ports:
//   clk, reset (async, active-high), flush
//   disp_*  : dispatch handshake plus operand values, ready flags and producer tags
//   cdb_*   : result broadcast used to wake waiting operands
//   exec_enable / exec_rs : enable and the 105-bit operand bus {op,width,base,imm,src,dest} sent to the exec unit
//   done_*  : single-cycle completion report to register update
//   count   : occupied entries
// Optional: when LSQ_PERF_CNT_EN is defined, adds the saturating counters perf_issued and perf_head_stall.
module lsu_issue_queue #(
    parameter int DEPTH       = 8,
    parameter int TAG_W       = 4,
    parameter int EXEC_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic                   disp_op,
    input  logic [2:0]             disp_width,
    input  logic [31:0]            disp_base,
    input  logic                   disp_base_rdy,
    input  logic [TAG_W-1:0]       disp_base_tag,
    input  logic [31:0]            disp_imm,
    input  logic [31:0]            disp_src,
    input  logic                   disp_src_rdy,
    input  logic [TAG_W-1:0]       disp_src_tag,
    input  logic [4:0]             disp_rd,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_tag,
    input  logic [31:0]            cdb_data,
    output logic                   exec_enable,
    output logic [104:0]           exec_rs,
    output logic                   done_valid,
    output logic [4:0]             done_rd,
    output logic                   done_is_store,
    output logic [$clog2(DEPTH):0] count
`ifdef LSQ_PERF_CNT_EN
    ,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_head_stall
`endif
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CYW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CYW-1:0] CYC_LAST = CYW'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_t;

    typedef struct packed {
        logic             op;
        logic [2:0]       width;
        logic [31:0]      base;
        logic             base_rdy;
        logic [TAG_W-1:0] base_tag;
        logic [31:0]      imm;
        logic [31:0]      src;
        logic             src_rdy;
        logic [TAG_W-1:0] src_tag;
        logic [4:0]       rd;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    entry_t          new_ent;
    entry_t          head_ent;

    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q, state_d;
    logic [CYW-1:0]  cyc_q, cyc_d;
    logic            exec_enable_q, exec_enable_d;
    logic [104:0]    exec_rs_q, exec_rs_d;
    logic            done_valid_q, done_valid_d;
    logic [4:0]      done_rd_q, done_rd_d;
    logic            done_is_store_q, done_is_store_d;

    logic            push, pop, head_elig;

    assign head_ent   = ent_q[head_q];
    assign disp_ready = (count_q < CW'(DEPTH));
    assign push       = disp_valid && disp_ready && !flush;
    // A load never waits on its src operand.
    assign head_elig  = (count_q != '0) && head_ent.base_rdy && (!head_ent.op || head_ent.src_rdy);

    // The new entry takes the same-cycle broadcast for any operand that is still waiting.
    always_comb begin
        new_ent.op       = disp_op;
        new_ent.width    = disp_width;
        new_ent.base     = disp_base;
        new_ent.base_rdy = disp_base_rdy;
        new_ent.base_tag = disp_base_tag;
        new_ent.imm      = disp_imm;
        new_ent.src      = disp_src;
        new_ent.src_rdy  = disp_src_rdy;
        new_ent.src_tag  = disp_src_tag;
        new_ent.rd       = disp_rd;
        if (cdb_valid && !disp_base_rdy && (disp_base_tag == cdb_tag)) begin
            new_ent.base     = cdb_data;
            new_ent.base_rdy = 1'b1;
        end
        if (cdb_valid && !disp_src_rdy && (disp_src_tag == cdb_tag)) begin
            new_ent.src     = cdb_data;
            new_ent.src_rdy = 1'b1;
        end
    end

    // Wakeup runs on every slot. A slot outside the head..tail window is rewritten in full before it is used again, so waking it is harmless.
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid && !ent_q[i].base_rdy && (ent_q[i].base_tag == cdb_tag)) begin
                ent_d[i].base     = cdb_data;
                ent_d[i].base_rdy = 1'b1;
            end
            if (cdb_valid && !ent_q[i].src_rdy && (ent_q[i].src_tag == cdb_tag)) begin
                ent_d[i].src     = cdb_data;
                ent_d[i].src_rdy = 1'b1;
            end
        end
        if (push) begin
            ent_d[tail_q] = new_ent;
        end
    end

    // Sequencer. Outputs are registered, so they are derived from the next state.
    always_comb begin
        state_d         = state_q;
        cyc_d           = cyc_q;
        exec_rs_d       = exec_rs_q;
        pop             = 1'b0;
        done_valid_d    = 1'b0;
        done_rd_d       = '0;
        done_is_store_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A flush cancels an issue in the same cycle, because the head is still un-issued.
                if (head_elig && !flush) begin
                    exec_rs_d = {head_ent.op, head_ent.width, head_ent.base,
                                 head_ent.imm, head_ent.src, head_ent.rd};
                    cyc_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cyc_q == CYC_LAST) begin
                    pop     = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cyc_d = cyc_q + CYW'(1);
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        exec_enable_d = (state_d == ST_BUSY);
        // done_valid goes high together with the last enable cycle, which is also the pop cycle.
        if ((state_d == ST_BUSY) && (cyc_d == CYC_LAST)) begin
            done_valid_d    = 1'b1;
            done_rd_d       = head_ent.op ? 5'd0 : head_ent.rd;
            done_is_store_d = head_ent.op;
        end
    end

    // Pointers. On flush, only an in-flight BUSY entry survives. It stays at the head until it pops.
    always_comb begin
        head_d = pop ? head_q + PW'(1) : head_q;
        if (flush) begin
            if ((state_q == ST_BUSY) && !pop) begin
                tail_d  = head_q + PW'(1);
                count_d = CW'(1);
            end else begin
                tail_d  = head_d;
                count_d = '0;
            end
        end else begin
            tail_d  = push ? tail_q + PW'(1) : tail_q;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            state_q         <= ST_IDLE;
            cyc_q           <= '0;
            exec_enable_q   <= 1'b0;
            exec_rs_q       <= '0;
            done_valid_q    <= 1'b0;
            done_rd_q       <= '0;
            done_is_store_q <= 1'b0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            state_q         <= state_d;
            cyc_q           <= cyc_d;
            exec_enable_q   <= exec_enable_d;
            exec_rs_q       <= exec_rs_d;
            done_valid_q    <= done_valid_d;
            done_rd_q       <= done_rd_d;
            done_is_store_q <= done_is_store_d;
        end
    end

    assign exec_enable   = exec_enable_q;
    assign exec_rs       = exec_rs_q;
    assign done_valid    = done_valid_q;
    assign done_rd       = done_rd_q;
    assign done_is_store = done_is_store_q;
    assign count         = count_q;

`ifdef LSQ_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_head_stall_q, perf_head_stall_d;

    always_comb begin
        perf_issued_d     = perf_issued_q;
        perf_head_stall_d = perf_head_stall_q;
        if (done_valid_q && (perf_issued_q != '1)) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if ((count_q != '0) && (state_q == ST_IDLE) && !head_elig && (perf_head_stall_q != '1)) begin
            perf_head_stall_d = perf_head_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued_q     <= '0;
            perf_head_stall_q <= '0;
        end else begin
            perf_issued_q     <= perf_issued_d;
            perf_head_stall_q <= perf_head_stall_d;
        end
    end

    assign perf_issued     = perf_issued_q;
    assign perf_head_stall = perf_head_stall_q;
`endif

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Self-checking bench for lsu_issue_queue. It uses a timeline reference model built on a queue of ops.
// Every cycle it checks enable, done, count, ready and exec_rs. Directed scenarios are followed by randomized traffic.
// Directed checks then confirm exact cycle numbers and field values.
module tb_lsu_issue_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 4;
    localparam int EXEC  = 3;

    logic clk = 1'b0;
    logic reset, flush;
    logic disp_valid, disp_ready, disp_op;
    logic [2:0] disp_width;
    logic [31:0] disp_base, disp_imm, disp_src, cdb_data;
    logic disp_base_rdy, disp_src_rdy, cdb_valid;
    logic [TAG_W-1:0] disp_base_tag, disp_src_tag, cdb_tag;
    logic [4:0] disp_rd, done_rd;
    logic exec_enable, done_valid, done_is_store;
    logic [104:0] exec_rs;
    logic [3:0] count;

    always #5 clk = ~clk;

    lsu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .EXEC_CYCLES(EXEC)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_width(disp_width), .disp_base(disp_base), .disp_base_rdy(disp_base_rdy),
        .disp_base_tag(disp_base_tag), .disp_imm(disp_imm), .disp_src(disp_src),
        .disp_src_rdy(disp_src_rdy), .disp_src_tag(disp_src_tag), .disp_rd(disp_rd),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .exec_enable(exec_enable), .exec_rs(exec_rs), .done_valid(done_valid),
        .done_rd(done_rd), .done_is_store(done_is_store), .count(count)
    );

    typedef struct {
        bit        op;
        bit [2:0]  w;
        bit [31:0] base;
        bit        brdy;
        bit [3:0]  btag;
        bit [31:0] imm;
        bit [31:0] src;
        bit        srdy;
        bit [3:0]  stag;
        bit [4:0]  rd;
    } ment_t;

    ment_t mq[$];
    ment_t m_rs;
    bit    m_busy;
    int    m_ti, m_next, cyc;
    int    n_checks, n_fail;

    // DUT observations, kept for the directed checks
    bit           prev_en;
    int           en_rise_cyc, last_done_cyc, n_done;
    logic [104:0] en_rise_rs;
    logic [4:0]   last_done_rd;
    logic         last_done_st;
    bit           saw_full;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; disp_valid = 0; disp_op = 0; disp_width = 0; disp_base = 0;
        disp_base_rdy = 0; disp_base_tag = 0; disp_imm = 0; disp_src = 0;
        disp_src_rdy = 0; disp_src_tag = 0; disp_rd = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic set_disp(input bit op, input bit [2:0] w, input bit [31:0] base, input bit brdy,
                            input bit [3:0] btag, input bit [31:0] imm, input bit [31:0] src,
                            input bit srdy, input bit [3:0] stag, input bit [4:0] rd);
        disp_valid = 1; disp_op = op; disp_width = w; disp_base = base; disp_base_rdy = brdy;
        disp_base_tag = btag; disp_imm = imm; disp_src = src; disp_src_rdy = srdy;
        disp_src_tag = stag; disp_rd = rd;
    endtask

    // Run one cycle. Check the outputs against the model, then advance the model using the inputs currently driven.
    task automatic step();
        bit exp_en, exp_done, elig, issue, push;
        logic [104:0] obs_rs, exp_rs;
        ment_t e, h;
        exp_en   = m_busy && (cyc >= m_ti + 1) && (cyc <= m_ti + EXEC);
        exp_done = m_busy && (cyc == m_ti + EXEC);
        check_eq("exec_enable", exec_enable, exp_en);
        check_eq("done_valid", done_valid, exp_done);
        check_eq("count", count, mq.size());
        check_eq("disp_ready", disp_ready, mq.size() < DEPTH);
        if (exp_en) begin
            obs_rs = exec_rs;
            if (!m_rs.op) obs_rs[36:5] = '0;
            exp_rs = {m_rs.op, m_rs.w, m_rs.base, m_rs.imm, (m_rs.op ? m_rs.src : 32'd0), m_rs.rd};
            check_eq("exec_rs", obs_rs, exp_rs);
        end
        if (exp_done) begin
            check_eq("done_rd", done_rd, m_rs.op ? 5'd0 : m_rs.rd);
            check_eq("done_is_store", done_is_store, m_rs.op);
        end
        if (exec_enable && !prev_en) begin en_rise_cyc = cyc; en_rise_rs = exec_rs; end
        prev_en = exec_enable;
        if (done_valid) begin
            n_done++; last_done_cyc = cyc; last_done_rd = done_rd; last_done_st = done_is_store;
        end
        if ((count == 4'd8) && !disp_ready) saw_full = 1;

        elig  = (mq.size() > 0) && mq[0].brdy && (!mq[0].op || mq[0].srdy);
        issue = !m_busy && (cyc >= m_next) && elig && !flush;
        push  = disp_valid && (mq.size() < DEPTH) && !flush;
        if (issue) begin m_busy = 1; m_ti = cyc; m_rs = mq[0]; end
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (!mq[i].brdy && mq[i].btag == cdb_tag) begin mq[i].base = cdb_data; mq[i].brdy = 1; end
                if (!mq[i].srdy && mq[i].stag == cdb_tag) begin mq[i].src = cdb_data; mq[i].srdy = 1; end
            end
        end
        if (exp_done) begin void'(mq.pop_front()); m_busy = 0; m_next = cyc + 2; end
        if (flush) begin
            if (m_busy) begin h = mq[0]; mq.delete(); mq.push_back(h); end
            else mq.delete();
        end
        if (push) begin
            e.op = disp_op; e.w = disp_width; e.imm = disp_imm; e.rd = disp_rd;
            e.base = disp_base; e.brdy = disp_base_rdy; e.btag = disp_base_tag;
            e.src = disp_src; e.srdy = disp_src_rdy; e.stag = disp_src_tag;
            if (!e.brdy && cdb_valid && e.btag == cdb_tag) begin e.base = cdb_data; e.brdy = 1; end
            if (!e.srdy && cdb_valid && e.stag == cdb_tag) begin e.src = cdb_data; e.srdy = 1; end
            mq.push_back(e);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        idle_inputs();
        n = 0;
        while ((mq.size() != 0 || m_busy || cyc < m_next) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check_eq("drain_timeout", 1, 0);
    endtask

    task automatic rand_step(input int disp_pct);
        idle_inputs();
        if ($urandom_range(0, 99) < disp_pct)
            set_disp($urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 15), $urandom, $urandom, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 15), $urandom_range(0, 31));
        cdb_valid = ($urandom_range(0, 9) < 3);
        cdb_tag   = $urandom_range(0, 15);
        cdb_data  = $urandom;
        flush     = ($urandom_range(0, 99) < 2);
        step();
    endtask

    initial begin
        int c0, nd0, acc, n;
        n_checks = 0; n_fail = 0; cyc = 0; m_busy = 0; m_ti = 0; m_next = 0;
        prev_en = 0; en_rise_cyc = -1; last_done_cyc = -1; n_done = 0; saw_full = 0;
        en_rise_rs = '0; last_done_rd = '0; last_done_st = 0;
        idle_inputs();
        reset = 1;
        #3;
        check_eq("rst_exec_enable", exec_enable, 0);
        check_eq("rst_exec_rs", exec_rs, 0);
        check_eq("rst_done_valid", done_valid, 0);
        check_eq("rst_done_rd", done_rd, 0);
        check_eq("rst_done_is_store", done_is_store, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_disp_ready", disp_ready, 1);
        @(posedge clk);
        #1;
        reset = 0;

        // Ready load
        c0 = cyc;
        set_disp(0, 3'd2, 32'h100, 1, 0, 32'h4, 32'h0, 0, 0, 5'd7);
        step();
        wait_idle();
        check_eq("t1_en_rise", en_rise_cyc, c0 + 2);
        check_eq("t1_base", en_rise_rs[100:69], 32'h100);
        check_eq("t1_imm", en_rise_rs[68:37], 32'h4);
        check_eq("t1_dest", en_rise_rs[4:0], 5'd7);
        check_eq("t1_done_cyc", last_done_cyc, c0 + 4);
        check_eq("t1_done_rd", last_done_rd, 5'd7);
        check_eq("t1_done_st", last_done_st, 0);

        // Store waiting for its data via the CDB
        c0 = cyc;
        set_disp(1, 3'd3, 32'h200, 1, 0, 32'h8, 32'h0, 0, 4'd3, 5'd9);
        step();
        idle_inputs();
        repeat (4) step();
        cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 32'hDEADBEEF;
        step();
        wait_idle();
        check_eq("t2_en_rise", en_rise_cyc, c0 + 7);
        check_eq("t2_src", en_rise_rs[36:5], 32'hDEADBEEF);
        check_eq("t2_done_rd", last_done_rd, 5'd0);
        check_eq("t2_done_st", last_done_st, 1);

        // Fill the queue with ready ops, then drain it
        nd0 = n_done; acc = 0; saw_full = 0;
        for (int i = 0; i < 14; i++) begin
            if (mq.size() < DEPTH) acc++;
            set_disp(i[0], 3'd1, 32'h1000 + i, 1, 0, 32'h10, 32'h5000 + i, 1, 0, 5'(i + 1));
            step();
        end
        wait_idle();
        check_eq("t3_full_seen", saw_full, 1);
        check_eq("t3_all_done", n_done - nd0, acc);

        // Dispatch bypass from a same-cycle broadcast
        c0 = cyc;
        set_disp(0, 3'd0, 32'h0, 0, 4'd5, 32'h0, 32'h0, 0, 0, 5'd3);
        cdb_valid = 1; cdb_tag = 4'd5; cdb_data = 32'h40;
        step();
        wait_idle();
        check_eq("t4_en_rise", en_rise_cyc, c0 + 2);
        check_eq("t4_base", en_rise_rs[100:69], 32'h40);

        // Flush in the second BUSY cycle
        c0 = cyc; nd0 = n_done;
        for (int i = 0; i < 4; i++) begin
            set_disp(1, 3'd2, 32'h300 + i, 1, 0, 32'h0, 32'hA0 + i, 1, 0, 5'(20 + i));
            flush = (i == 3);
            step();
        end
        wait_idle();
        check_eq("t5_done_cyc", last_done_cyc, c0 + 4);
        check_eq("t5_one_done", n_done - nd0, 1);
        check_eq("t5_count", count, 0);
        check_eq("t5_no_reissue", en_rise_cyc, c0 + 2);

        // Asynchronous reset in the middle of BUSY
        nd0 = n_done;
        set_disp(0, 3'd0, 32'h700, 1, 0, 32'h0, 32'h0, 0, 0, 5'd11);
        step();
        step();
        idle_inputs();
        n = 0;
        while (!(m_busy && cyc == m_ti + 2) && n < 20) begin step(); n++; end
        if (n >= 20) check_eq("t6_timeout", 1, 0);
        #2 reset = 1;
        #1;
        check_eq("t6_exec_enable", exec_enable, 0);
        check_eq("t6_count", count, 0);
        check_eq("t6_done_valid", done_valid, 0);
        @(posedge clk);
        #1;
        check_eq("t6_no_done", n_done - nd0, 0);
        check_eq("t6_done_after", done_valid, 0);
        reset = 0;
        mq.delete(); m_busy = 0; m_next = 0; prev_en = 0; cyc++;

        // Randomized traffic: moderate load first, then heavy load
        for (int i = 0; i < 800; i++) rand_step(50);
        for (int i = 0; i < 800; i++) rand_step(90);
        idle_inputs();
        flush = 1;
        step();
        wait_idle();
        check_eq("end_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
